// File: rtl/id_ex_operand_stage_pkg.sv
// Shared CPU datapath types for the ID/EX operand stage: word and register
// index types, ALU operation encoding and the latched ID/EX bundle.
package id_ex_operand_stage_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int REG_WIDTH  = 5;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [REG_WIDTH-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        logic     valid;
        regbits_t rs;
        regbits_t rt;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        logic     alusrc;
        aluop_t   aluop;
        regbits_t wsel;
        logic     regwr;
        logic     memrd;
        logic     memwr;
    } id_ex_t;

    // An all-zero bundle is a bubble: no side effects and aluop = ALU_SLL.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ALU operand interface: the ID/EX stage drives operands and operation,
// the ALU consumes them.
interface id_ex_operand_stage_if;
    import id_ex_operand_stage_pkg::*;

    word_t  portA;
    word_t  portB;
    aluop_t aluop;

    modport master (output portA, output portB, output aluop);
    modport slave  (input  portA, input  portB, input  aluop);
endinterface

// File: rtl/id_ex_operand_stage_forward_unit.sv
// Combinational RAW-hazard bypass for one source operand; EX/MEM has
// priority over MEM/WB and register $0 is never bypassed.
module id_ex_operand_stage_forward_unit
    import id_ex_operand_stage_pkg::*;
(
    input  regbits_t idx,
    input  word_t    rdat,
    input  logic     exmem_regwr,
    input  regbits_t exmem_wsel,
    input  word_t    exmem_res,
    input  logic     memwb_regwr,
    input  regbits_t memwb_wsel,
    input  word_t    memwb_res,
    output word_t    fwd
);

    // select the youngest in-flight producer of idx
    always_comb begin
        fwd = rdat;
        if (idx == 5'd0) begin
            fwd = rdat;
        end else if (exmem_regwr && (exmem_wsel == idx)) begin
            fwd = exmem_res;
        end else if (memwb_regwr && (memwb_wsel == idx)) begin
            fwd = memwb_res;
        end else begin
            fwd = rdat;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble
// insertion, feeding the ALU operand interface.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    input  logic [WORD_W-1:0] id_imm,
    input  logic              id_alusrc,
    input  aluop_t            id_aluop,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic              id_regwr,
    input  logic              id_memrd,
    input  logic              id_memwr,
    input  logic              exmem_regwr,
    input  logic [REG_W-1:0]  exmem_wsel,
    input  logic [WORD_W-1:0] exmem_res,
    input  logic              memwb_regwr,
    input  logic [REG_W-1:0]  memwb_wsel,
    input  logic [WORD_W-1:0] memwb_res,
    id_ex_operand_stage_if.master alu,
    output logic [WORD_W-1:0] ex_stdata,
    output logic [REG_W-1:0]  ex_wsel,
    output logic              ex_regwr,
    output logic              ex_memrd,
    output logic              ex_memwr,
    output logic              ex_valid,
    output logic              hazard_stall
);

    id_ex_t id_ex_q;
    id_ex_t id_ex_d;
    logic   hazard_s;
    word_t  fwd_rs_s;
    word_t  fwd_rt_s;

    // load-use: a load in EX whose destination is read by the instruction in ID
    always_comb begin
        hazard_s = id_ex_q.valid && id_ex_q.memrd && (id_ex_q.wsel != 5'd0) &&
                   ((id_ex_q.wsel == id_rs) ||
                    (id_uses_rt && (id_ex_q.wsel == id_rt)));
    end

    // next-state: flush beats hold, hold beats hazard bubble
    always_comb begin
        id_ex_d = id_ex_q;
        if (flush) begin
            id_ex_d = ID_EX_BUBBLE;
        end else if (!en) begin
            id_ex_d = id_ex_q;
        end else if (hazard_s) begin
            id_ex_d = ID_EX_BUBBLE;
        end else begin
            id_ex_d.valid  = 1'b1;
            id_ex_d.rs     = id_rs;
            id_ex_d.rt     = id_rt;
            id_ex_d.rdat1  = id_rdat1;
            id_ex_d.rdat2  = id_rdat2;
            id_ex_d.imm    = id_imm;
            id_ex_d.alusrc = id_alusrc;
            id_ex_d.aluop  = id_aluop;
            id_ex_d.wsel   = id_wsel;
            id_ex_d.regwr  = id_regwr;
            id_ex_d.memrd  = id_memrd;
            id_ex_d.memwr  = id_memwr;
        end
    end

    // pipeline register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            id_ex_q <= ID_EX_BUBBLE;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    id_ex_operand_stage_forward_unit u_fwd_rs (
        .idx         (id_ex_q.rs),
        .rdat        (id_ex_q.rdat1),
        .exmem_regwr (exmem_regwr),
        .exmem_wsel  (exmem_wsel),
        .exmem_res   (exmem_res),
        .memwb_regwr (memwb_regwr),
        .memwb_wsel  (memwb_wsel),
        .memwb_res   (memwb_res),
        .fwd         (fwd_rs_s)
    );

    id_ex_operand_stage_forward_unit u_fwd_rt (
        .idx         (id_ex_q.rt),
        .rdat        (id_ex_q.rdat2),
        .exmem_regwr (exmem_regwr),
        .exmem_wsel  (exmem_wsel),
        .exmem_res   (exmem_res),
        .memwb_regwr (memwb_regwr),
        .memwb_wsel  (memwb_wsel),
        .memwb_res   (memwb_res),
        .fwd         (fwd_rt_s)
    );

    // stores always see forwarded rt, even when portB carries the immediate
    assign alu.portA    = fwd_rs_s;
    assign alu.portB    = id_ex_q.alusrc ? id_ex_q.imm : fwd_rt_s;
    assign alu.aluop    = id_ex_q.aluop;
    assign ex_stdata    = fwd_rt_s;
    assign ex_wsel      = id_ex_q.wsel;
    assign ex_regwr     = id_ex_q.regwr;
    assign ex_memrd     = id_ex_q.memrd;
    assign ex_memwr     = id_ex_q.memwr;
    assign ex_valid     = id_ex_q.valid;
    assign hazard_stall = hazard_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage: forwarding, $0 guard,
// load-use bubbles, store data path, flush/hold priority and async reset.
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST, en, flush;
    logic [4:0]  id_rs, id_rt, id_wsel, exmem_wsel, memwb_wsel;
    logic        id_uses_rt, id_alusrc, id_regwr, id_memrd, id_memwr;
    logic [31:0] id_rdat1, id_rdat2, id_imm, exmem_res, memwb_res;
    aluop_t      id_aluop;
    logic        exmem_regwr, memwb_regwr;
    logic [31:0] ex_stdata;
    logic [4:0]  ex_wsel;
    logic        ex_regwr, ex_memrd, ex_memwr, ex_valid, hazard_stall;

    int n_vec = 0;
    int n_err = 0;

    id_ex_operand_stage_if alu_if ();

    id_ex_operand_stage dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_wsel(id_wsel),
        .id_regwr(id_regwr), .id_memrd(id_memrd), .id_memwr(id_memwr),
        .exmem_regwr(exmem_regwr), .exmem_wsel(exmem_wsel), .exmem_res(exmem_res),
        .memwb_regwr(memwb_regwr), .memwb_wsel(memwb_wsel), .memwb_res(memwb_res),
        .alu(alu_if.master),
        .ex_stdata(ex_stdata), .ex_wsel(ex_wsel), .ex_regwr(ex_regwr),
        .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_valid(ex_valid),
        .hazard_stall(hazard_stall)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [31:0] d1,
                          input logic [4:0] rt, input logic [31:0] d2,
                          input logic urt, input logic [31:0] imm, input logic asrc,
                          input aluop_t op, input logic [4:0] ws,
                          input logic rw, input logic mr, input logic mw);
        id_rs = rs; id_rdat1 = d1; id_rt = rt; id_rdat2 = d2; id_uses_rt = urt;
        id_imm = imm; id_alusrc = asrc; id_aluop = op; id_wsel = ws;
        id_regwr = rw; id_memrd = mr; id_memwr = mw;
    endtask

    task automatic clr_wb();
        exmem_regwr = 1'b0; exmem_wsel = 5'd0; exmem_res = 32'd0;
        memwb_regwr = 1'b0; memwb_wsel = 5'd0; memwb_res = 32'd0;
    endtask

    initial begin
        nRST = 1'b0; en = 1'b1; flush = 1'b0;
        set_id(5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, ALU_SLL, 5'd0, 1'b0, 1'b0, 1'b0);
        clr_wb();
        #2;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_aluop", 32'(alu_if.aluop), 32'd0);
        chk("rst_porta", alu_if.portA, 32'd0);
        step();
        nRST = 1'b1;

        // EX/MEM over MEM/WB forwarding on rs
        set_id(5'd3, 32'h11, 5'd4, 32'h22, 1'b1, 32'd0, 1'b0, ALU_ADD, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        chk("ld_valid", 32'(ex_valid), 32'd1);
        chk("ld_wsel", 32'(ex_wsel), 32'd9);
        chk("ld_aluop", 32'(alu_if.aluop), 32'd2);
        chk("ld_porta", alu_if.portA, 32'h11);
        chk("ld_portb", alu_if.portB, 32'h22);
        exmem_regwr = 1'b1; exmem_wsel = 5'd3; exmem_res = 32'hDEAD;
        #1;
        chk("fwd_exmem", alu_if.portA, 32'hDEAD);
        chk("fwd_rt_nomatch", alu_if.portB, 32'h22);
        memwb_regwr = 1'b1; memwb_wsel = 5'd3; memwb_res = 32'hBEEF;
        #1;
        chk("fwd_exmem_prio", alu_if.portA, 32'hDEAD);
        exmem_regwr = 1'b0;
        #1;
        chk("fwd_memwb", alu_if.portA, 32'hBEEF);

        // asynchronous reset while a valid instruction is latched
        clr_wb();
        nRST = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_regwr", 32'(ex_regwr), 32'd0);
        chk("arst_wsel", 32'(ex_wsel), 32'd0);
        chk("arst_porta", alu_if.portA, 32'd0);
        chk("arst_portb", alu_if.portB, 32'd0);
        chk("arst_aluop", 32'(alu_if.aluop), 32'd0);
        nRST = 1'b1;

        // $0 is never forwarded
        set_id(5'd0, 32'd0, 5'd4, 32'h22, 1'b1, 32'd0, 1'b0, ALU_ADD, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        exmem_regwr = 1'b1; exmem_wsel = 5'd0; exmem_res = 32'h55;
        memwb_regwr = 1'b1; memwb_wsel = 5'd0; memwb_res = 32'h66;
        #1;
        chk("zero_guard", alu_if.portA, 32'd0);
        clr_wb();

        // load-use hazard: lw $5 in EX
        set_id(5'd1, 32'h100, 5'd0, 32'd0, 1'b0, 32'h4, 1'b1, ALU_ADD, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        chk("lw_memrd", 32'(ex_memrd), 32'd1);
        chk("lw_portb_imm", alu_if.portB, 32'h4);
        set_id(5'd2, 32'h200, 5'd5, 32'd0, 1'b0, 32'h0, 1'b1, ALU_ADD, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("hz_rt_unused", 32'(hazard_stall), 32'd0);
        set_id(5'd5, 32'd0, 5'd6, 32'h66, 1'b1, 32'd0, 1'b0, ALU_SUB, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("hz_rs", 32'(hazard_stall), 32'd1);
        step();
        chk("bub_valid", 32'(ex_valid), 32'd0);
        chk("bub_regwr", 32'(ex_regwr), 32'd0);
        chk("bub_memrd", 32'(ex_memrd), 32'd0);
        chk("bub_aluop", 32'(alu_if.aluop), 32'd0);
        chk("bub_hz_clear", 32'(hazard_stall), 32'd0);
        step();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_wsel", 32'(ex_wsel), 32'd8);
        chk("add_aluop", 32'(alu_if.aluop), 32'd3);
        chk("add_portb", alu_if.portB, 32'h66);

        // store: portB takes imm, ex_stdata takes forwarded rt
        set_id(5'd2, 32'h200, 5'd7, 32'd0, 1'b1, 32'h8, 1'b1, ALU_ADD, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        memwb_regwr = 1'b1; memwb_wsel = 5'd7; memwb_res = 32'h1234;
        #1;
        chk("sw_portb", alu_if.portB, 32'h8);
        chk("sw_stdata", ex_stdata, 32'h1234);
        chk("sw_memwr", 32'(ex_memwr), 32'd1);
        chk("sw_porta", alu_if.portA, 32'h200);
        clr_wb();

        // flush beats hold
        en = 1'b0; flush = 1'b1;
        step();
        en = 1'b1; flush = 1'b0;
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_memwr", 32'(ex_memwr), 32'd0);
        chk("fl_portb", alu_if.portB, 32'd0);

        // hold for 3 cycles while ID changes
        set_id(5'd3, 32'hA5, 5'd4, 32'h5A, 1'b1, 32'd0, 1'b0, ALU_OR, 5'd10, 1'b1, 1'b0, 1'b0);
        step();
        en = 1'b0;
        set_id(5'd6, 32'hFF, 5'd7, 32'hEE, 1'b1, 32'd0, 1'b0, ALU_XOR, 5'd12, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid", 32'(ex_valid), 32'd1);
            chk("hold_wsel", 32'(ex_wsel), 32'd10);
            chk("hold_porta", alu_if.portA, 32'hA5);
            chk("hold_aluop", 32'(alu_if.aluop), 32'd5);
        end

        // hold keeps a pending hazard
        en = 1'b1;
        set_id(5'd1, 32'h100, 5'd0, 32'd0, 1'b0, 32'h4, 1'b1, ALU_ADD, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(5'd5, 32'd0, 5'd6, 32'h66, 1'b1, 32'd0, 1'b0, ALU_SUB, 5'd8, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step();
        chk("hold_hz", 32'(hazard_stall), 32'd1);
        chk("hold_hz_memrd", 32'(ex_memrd), 32'd1);

        // flush together with hazard
        en = 1'b1; flush = 1'b1;
        #1;
        chk("flhz_report", 32'(hazard_stall), 32'd1);
        step();
        flush = 1'b0;
        chk("flhz_valid", 32'(ex_valid), 32'd0);
        chk("flhz_clear", 32'(hazard_stall), 32'd0);

        // reset during a held load-use stall
        set_id(5'd1, 32'h100, 5'd0, 32'd0, 1'b0, 32'h4, 1'b1, ALU_ADD, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(5'd5, 32'd0, 5'd6, 32'h66, 1'b1, 32'd0, 1'b0, ALU_SUB, 5'd8, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        #1;
        nRST = 1'b0;
        #1;
        chk("rst_stall_hz", 32'(hazard_stall), 32'd0);
        chk("rst_stall_memrd", 32'(ex_memrd), 32'd0);
        nRST = 1'b1;
        en = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
